// File: rtl/water_level_sensor_filter.sv
// Probe front end: two-flop synchroniser, per-probe debouncer, startup gate and conflict filter.
// Optional sticky conflict flag enabled by defining CONFLICT_LATCH_EN.
module water_level_sensor_filter #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CONFLICT_CYCLES = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic low_sensor,
  input  logic mid_sensor,
  input  logic high_sensor,
  input  logic clear_conflict,
  output logic low_water_level,
  output logic mid_water_level,
  output logic high_water_level,
  output logic conflicting_values,
  output logic sensors_ready
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(DEBOUNCE_CYCLES + 2);
  localparam int CW = $clog2(CONFLICT_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] START_LAST = SW'(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CONF_MAX = CW'(CONFLICT_CYCLES);

  typedef enum logic {STARTUP, RUN} state_t;

  // Probe order in every vector: [0] low, [1] mid, [2] high.
  logic [2:0]    sync1, sync2;
  logic [2:0]    q, q_next;
  logic [DW-1:0] cnt [3];
  logic [DW-1:0] cnt_next [3];

  state_t        state, state_next;
  logic [SW-1:0] start_cnt, start_cnt_next;

  logic          bad;
  logic [CW-1:0] pcnt, pcnt_next;
  logic          conf_next;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {high_sensor, mid_sensor, low_sensor};
      sync2 <= sync1;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    q_next = q;
    for (int i = 0; i < 3; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != q[i]) begin
        if (cnt[i] == DEB_LAST) begin
          q_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + DW'(1);
        end
      end
    end
  end

  // NOTE: the small debounce counter array is reset like any other state, not left as memory.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      q <= q_next;
      for (int i = 0; i < 3; i++) cnt[i] <= cnt_next[i];
    end
  end

  always_comb begin
    state_next     = state;
    start_cnt_next = start_cnt;
    if (state == STARTUP) begin
      if (start_cnt == START_LAST) begin
        state_next = RUN;
      end else begin
        start_cnt_next = start_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= STARTUP;
      start_cnt <= '0;
    end else begin
      state     <= state_next;
      start_cnt <= start_cnt_next;
    end
  end

  // A higher probe wet while a lower one is dry cannot happen in a real tank.
  assign bad = (q[1] & ~q[0]) | (q[2] & ~q[1]);

  always_comb begin
    pcnt_next = pcnt;
    conf_next = conflicting_values;
    if (state != RUN) begin
      pcnt_next = '0;
      conf_next = 1'b0;
    end else if (!bad) begin
      pcnt_next = '0;
`ifdef CONFLICT_LATCH_EN
      if (clear_conflict) conf_next = 1'b0;
`else
      conf_next = 1'b0;
`endif
    end else if (pcnt != CONF_MAX) begin
      pcnt_next = pcnt + CW'(1);
      if (pcnt == CONF_MAX - CW'(1)) conf_next = 1'b1;
    end
  end

`ifndef CONFLICT_LATCH_EN
  logic unused_clear;
  assign unused_clear = clear_conflict;
`endif

  // Outputs are registered from next-state values so levels track q with no extra delay.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pcnt               <= '0;
      conflicting_values <= 1'b0;
      sensors_ready      <= 1'b0;
      low_water_level    <= 1'b0;
      mid_water_level    <= 1'b0;
      high_water_level   <= 1'b0;
    end else begin
      pcnt               <= pcnt_next;
      conflicting_values <= conf_next;
      sensors_ready      <= (state_next == RUN);
      low_water_level    <= (state_next == RUN) & q_next[0];
      mid_water_level    <= (state_next == RUN) & q_next[1];
      high_water_level   <= (state_next == RUN) & q_next[2];
    end
  end

endmodule
